disp_scan_driver: RTL and testbench

- Time-multiplexed 4-digit 7-segment scan driver; the consuming end of the 4-bit display-code interface.
- Drives the 2-bit digit select into the upstream code muxes (time digits, illegal-set error pattern) and samples the returned 4-bit code.
- Decodes the code to active-low segments and drives active-low anodes with inter-digit blanking.
- Sits between the stopwatch display muxes and the board's LED pins.

---
 rtl/disp_scan_driver_pkg.sv | 41 ++++
 rtl/disp_scan_driver_if.sv | 34 +++
 rtl/disp_scan_driver_seg_decoder.sv | 30 +++
 rtl/disp_scan_driver.sv | 116 +++++++++++
 tb/tb_disp_scan_driver.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/disp_scan_driver_pkg.sv
// Shared display types, 4-bit display-code map and active-low 7-segment glyphs.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package disp_pkg;

    typedef logic [3:0] disp_code_t;
    typedef logic [6:0] seg_t;

    localparam disp_code_t CODE_ZERO  = 4'b0000;
    localparam disp_code_t CODE_ONE   = 4'b0001;
    localparam disp_code_t CODE_TWO   = 4'b0010;
    localparam disp_code_t CODE_THREE = 4'b0011;
    localparam disp_code_t CODE_FOUR  = 4'b0100;
    localparam disp_code_t CODE_FIVED = 4'b0101;
    localparam disp_code_t CODE_SIX   = 4'b0110;
    localparam disp_code_t CODE_LBRK  = 4'b0111;
    localparam disp_code_t CODE_RBRK  = 4'b1000;
    localparam disp_code_t CODE_FIVE  = 4'b1001;
    localparam disp_code_t CODE_NINE  = 4'b1010;
    localparam disp_code_t CODE_SEVEN = 4'b1011;
    localparam disp_code_t CODE_EIGHT = 4'b1100;
    localparam disp_code_t CODE_DASH  = 4'b1101;
    localparam disp_code_t CODE_BLANK = 4'b1110;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_LBRK  = 7'b1000110;
    localparam seg_t SEG_RBRK  = 7'b1110000;
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/disp_scan_driver_if.sv
// Display-code bus between the upstream code muxes (master) and the scan driver (slave).
// The blink request only exists when DISP_BLINK_EN is defined.
interface disp_scan_driver_if;
    import disp_pkg::*;

    logic       en;
    disp_code_t code;
    logic [3:0] dp_mask;
    logic [1:0] sel;
    logic [3:0] an;
    seg_t       seg;
    logic       dp;
    logic       frame_tick;
`ifdef DISP_BLINK_EN
    logic       blink;
`endif

    modport master (
        output en, code, dp_mask,
`ifdef DISP_BLINK_EN
        output blink,
`endif
        input  sel, an, seg, dp, frame_tick
    );

    modport slave (
        input  en, code, dp_mask,
`ifdef DISP_BLINK_EN
        input  blink,
`endif
        output sel, an, seg, dp, frame_tick
    );

endinterface

// File: rtl/disp_scan_driver_seg_decoder.sv
// Combinational display-code to active-low segment decoder; codes 1110/1111 blank.
module seg_decoder
    import disp_pkg::*;
(
    input  disp_code_t code_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            CODE_ZERO:  seg_o = SEG_0;
            CODE_ONE:   seg_o = SEG_1;
            CODE_TWO:   seg_o = SEG_2;
            CODE_THREE: seg_o = SEG_3;
            CODE_FOUR:  seg_o = SEG_4;
            CODE_FIVED: seg_o = SEG_5;
            CODE_SIX:   seg_o = SEG_6;
            CODE_LBRK:  seg_o = SEG_LBRK;
            CODE_RBRK:  seg_o = SEG_RBRK;
            CODE_FIVE:  seg_o = SEG_5;
            CODE_NINE:  seg_o = SEG_9;
            CODE_SEVEN: seg_o = SEG_7;
            CODE_EIGHT: seg_o = SEG_8;
            CODE_DASH:  seg_o = SEG_DASH;
            default:    seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_scan_driver.sv
// 4-digit time-multiplexed 7-segment scan driver with inter-digit anode blanking.
// Optional blink gating of the anodes when DISP_BLINK_EN is defined.
module disp_scan_driver
    import disp_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                reset,
    disp_scan_driver_if.slave   bus
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    an_q, an_d;
    seg_t          seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          slot_end;
    logic          frame_tick;
    logic          dark;

    seg_decoder u_dec (
        .code_i (bus.code),
        .seg_o  (seg_d)
    );

    assign slot_end   = (cnt_q == CW'(PRESCALE - 1));
    assign frame_tick = bus.en && slot_end && (sel_q == 2'd3);

`ifdef DISP_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_on_q, phase_on_d;

    // Phase advances only on whole frames so a blink never cuts a scan short.
    always_comb begin
        bcnt_d     = bcnt_q;
        phase_on_d = phase_on_q;
        if (!bus.blink) begin
            bcnt_d     = '0;
            phase_on_d = 1'b1;
        end else if (frame_tick) begin
            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d     = '0;
                phase_on_d = ~phase_on_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt_q     <= '0;
            phase_on_q <= 1'b1;
        end else begin
            bcnt_q     <= bcnt_d;
            phase_on_q <= phase_on_d;
        end
    end

    assign dark = bus.blink && !phase_on_q;
`else
    assign dark = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        sel_d = sel_q;
        if (bus.en) begin
            if (slot_end) begin
                cnt_d = '0;
                sel_d = sel_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Anodes stay off for the first BLANK_CYCLES of each slot so the previous
    // digit's segments never ghost onto the newly selected digit.
    always_comb begin
        an_d = AN_OFF;
        if (bus.en && !(cnt_q < CW'(BLANK_CYCLES)) && !dark)
            an_d = ~(4'b0001 << sel_q);
        dp_d = ~bus.dp_mask[sel_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sel_q <= 2'd0;
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_disp_scan_driver.sv
// Randomized bench for disp_scan_driver against an enabled-cycle-count model,
// plus directed literal checks of reset, scan order, glyphs, enable and reset.
module tb_disp_scan_driver;
    import disp_pkg::*;

    localparam int P  = 4;
    localparam int B  = 1;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en_r = 1'b0;
    logic [3:0] code_r = 4'd0;
    logic [3:0] dpm_r = 4'd0;
    logic       err_mode = 1'b0;
    logic       chk_on = 1'b0;
`ifdef DISP_BLINK_EN
    logic       blink_r = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    disp_scan_driver_if bus();

    function automatic logic [3:0] err_code(input logic [1:0] s);
        case (s)
            2'd0:    return 4'b1010;
            2'd1:    return 4'b1001;
            2'd2:    return 4'b1000;
            default: return 4'b0111;
        endcase
    endfunction

    assign bus.en      = en_r;
    assign bus.dp_mask = dpm_r;
    assign bus.code    = err_mode ? err_code(bus.sel) : code_r;
`ifdef DISP_BLINK_EN
    assign bus.blink   = blink_r;
`endif

    disp_scan_driver #(.PRESCALE(P), .BLANK_CYCLES(B), .BLINK_FRAMES(BF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] GLY [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1000110,
                             7'b1110000, 7'b0010010, 7'b0010000, 7'b1111000,
                             7'b0000000, 7'b0111111, 7'b1111111, 7'b1111111};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: n = enabled cycles since reset; slot position and digit follow by arithmetic.
    int         n = 0;
    int         bc = 0;
    bit         on = 1'b1;
    int         mc, ms;
    bit         mft;
    logic [3:0] e_an = 4'hF;
    logic [3:0] onehot;
    logic [6:0] e_seg = 7'h7F;
    logic       e_dp = 1'b1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n = 0; bc = 0; on = 1'b1;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            mc = n % P;
            ms = (n / P) % 4;
            mft = en_r && (mc == P - 1) && (ms == 3);
            e_seg = GLY[bus.code];
            e_dp = ~dpm_r[ms];
            onehot = 4'b0001 << ms;
            e_an = (en_r && mc >= B) ? ~onehot : 4'hF;
`ifdef DISP_BLINK_EN
            if (blink_r && !on) e_an = 4'hF;
            if (!blink_r) begin
                bc = 0; on = 1'b1;
            end else if (mft) begin
                bc++;
                if (bc == BF) begin bc = 0; on = !on; end
            end
`endif
            if (en_r) n++;
        end
    end

    always @(negedge clk) begin
        if (chk_on && !reset) begin
            chk("sel", bus.sel, (n / P) % 4);
            chk("an", bus.an, e_an);
            chk("seg", bus.seg, e_seg);
            chk("dp", bus.dp, e_dp);
            chk("frame_tick", bus.frame_tick, en_r && (n % P == P - 1) && ((n / P) % 4 == 3));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [3:0] an_seq [6] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD};
    logic [1:0] sel_seq [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};

    initial begin
        int ft_cnt, k, saved_cnt;
        logic [1:0] saved_sel;

        en_r = 1'b1;
        repeat (3) tick();
        chk("rst_an", bus.an, 4'b1111);
        chk("rst_seg", bus.seg, 7'b1111111);
        chk("rst_dp", bus.dp, 1'b1);
        chk("rst_sel", bus.sel, 2'd0);
        chk("rst_ft", bus.frame_tick, 1'b0);

        // scan order straight out of reset
        chk_on = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("seq_an", bus.an, an_seq[i]);
            chk("seq_sel", bus.sel, sel_seq[i]);
        end
        tick();

        ft_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            if (bus.frame_tick) ft_cnt++;
            tick();
        end
        chk("ft_per_48", ft_cnt, 3);

        // error pattern via sel-driven mux
        err_mode = 1'b1;
        dpm_r = 4'b0100;
        repeat (2) tick();
        for (int i = 0; i < 20; i++) begin
            case (bus.an)
                4'b1110: chk("err_d0", bus.seg, 7'b0010000);
                4'b1101: chk("err_d1", bus.seg, 7'b0010010);
                4'b1011: chk("err_d2", bus.seg, 7'b1110000);
                4'b0111: chk("err_d3", bus.seg, 7'b1000110);
                default: ;
            endcase
            if (bus.an != 4'hF) chk("err_dp", bus.dp, (bus.an == 4'b1011) ? 1'b0 : 1'b1);
            tick();
        end

        // mid-slot code change
        err_mode = 1'b0;
        code_r = 4'b0000;
        dpm_r = 4'b0000;
        k = 0;
        while ((n % P) != 2 && k < 20) begin tick(); k++; end
        chk("mid_wait", ((n % P) == 2), 1'b1);
        chk("mid_old", bus.seg, 7'b1000000);
        saved_sel = bus.sel;
        code_r = 4'b1100;
        tick();
        chk("mid_new", bus.seg, 7'b0000000);
        chk("mid_sel", bus.sel, saved_sel);

        // enable freeze and resume
        k = 0;
        while ((n % P) != 1 && k < 20) begin tick(); k++; end
        saved_cnt = n % P;
        saved_sel = bus.sel;
        en_r = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("en_an", bus.an, 4'b1111);
            chk("en_sel", bus.sel, saved_sel);
            chk("en_ft", bus.frame_tick, 1'b0);
        end
        en_r = 1'b1;
        k = 0;
        while (bus.sel == saved_sel && k < 20) begin tick(); k++; end
        chk("en_resume", k, P - saved_cnt);

`ifdef DISP_BLINK_EN
        blink_r = 1'b1;
        repeat (8 * 4 * P) tick();
        blink_r = 1'b0;
        repeat (4 * P) tick();
`endif

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            en_r = ($urandom_range(0, 7) != 0);
            code_r = 4'($urandom_range(0, 15));
            dpm_r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) err_mode = ~err_mode;
`ifdef DISP_BLINK_EN
            if ($urandom_range(0, 199) == 0) blink_r = ~blink_r;
`endif
            tick();
        end

        // asynchronous reset mid-slot
        en_r = 1'b1;
        err_mode = 1'b0;
        code_r = 4'b0001;
        dpm_r = 4'b1111;
        repeat (6) tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_an", bus.an, 4'b1111);
        chk("arst_seg", bus.seg, 7'b1111111);
        chk("arst_dp", bus.dp, 1'b1);
        chk("arst_sel", bus.sel, 2'd0);
        tick();
        reset = 1'b0;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (bus.an == 4'hF && k < 20);
        chk("first_lit_cycle", k, B + 1);
        chk("first_lit_an", bus.an, 4'b1110);
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
